// File: rtl/sdram_burst_sequencer.sv
// sdram_burst_sequencer
//
// Host-side burst sequencer sitting between the host request interface and
// control_interface. It accepts level-sensitive read/write requests, issues a
// READA/WRITEA command and holds it until control_interface acknowledges it.
// It then times the data phase:
//   - IN_REQ window for write data
//   - OUT_VALID window for registered read data
//   - SDRAM DQM lanes
//   - page-mode stop/done pulses and the DONE strobe
// Timing is set by the CAS latency (CL), ACT-to-command delay (RCD) and write
// recovery (TWR) parameters.
//
// Ports
//   CLK        single clock, all logic on the rising edge
//   RESET      synchronous reset, active-high
//   ADDR       burst start address, captured when a request is accepted
//   RD / WR    level read / write requests (read wins when both are high)
//   LENGTH     burst length in beats, captured when a request is accepted
//   DM         host write byte mask, 1 = lane masked
//   DQ_IN      read data from the DQ pad
//   CMDACK     control_interface has taken the command
//   CMD        00 NOP, 01 READA, 10 WRITEA
//   CMD_ADDR   captured burst address
//   ACT        a transfer is in progress
//   IN_REQ     host must present write data next cycle
//   OUT_VALID  DATAOUT holds a valid read beat
//   DATAOUT    registered read data
//   DQM        SDRAM data mask lanes
//   PM_STOP    one-cycle pulse: issue burst terminate
//   PM_DONE    one-cycle pulse: page burst finished
//   DONE       one-cycle pulse: transfer complete
//   ERR        one-cycle pulse: zero-length request rejected
module sdram_burst_sequencer #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 23,
  parameter int LEN_W = 8,
  parameter int CL    = 3,
  parameter int RCD   = 3,
  parameter int TWR   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [ASIZE-1:0]     ADDR,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [LEN_W-1:0]     LENGTH,
  input  logic [DSIZE/8-1:0]   DM,
  input  logic [DSIZE-1:0]     DQ_IN,
  input  logic                 CMDACK,
  output logic [1:0]           CMD,
  output logic [ASIZE-1:0]     CMD_ADDR,
  output logic                 ACT,
  output logic                 IN_REQ,
  output logic                 OUT_VALID,
  output logic [DSIZE-1:0]     DATAOUT,
  output logic [DSIZE/8-1:0]   DQM,
  output logic                 PM_STOP,
  output logic                 PM_DONE,
  output logic                 DONE,
  output logic                 ERR
);

  localparam int MW      = DSIZE / 8;
  // Largest count ever reached is RCD+CL+L+1 (read) or RCD+L+TWR (write).
  // Sizing for RCD+CL+2**LEN_W+TWR covers both with margin, so the counter
  // never wraps, even on a maximum-length burst.
  localparam int CNT_MAX = RCD + CL + (2 ** LEN_W) + TWR;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [31:0] RCD_U = RCD;
  localparam logic [31:0] CL_U  = CL;
  localparam logic [31:0] TWR_U = TWR;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_XFER
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_rd_q, is_rd_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ASIZE-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic [MW-1:0]     dm_q;
  logic [DSIZE-1:0]  data_q;

  logic [31:0]       c32;
  logic [31:0]       l32;

  logic              wr_inreq_win;
  logic              wr_mask_win;
  logic              rd_mask_win;
  logic              rd_valid_win;
  logic              stop_pt;
  logic              xfer_done;

  assign c32 = 32'(cnt_q);
  assign l32 = 32'(len_q);

  // Phase windows inside XFER, all measured from the cycle after CMDACK.
  // Every bound is at least zero because L >= 1 and RCD >= 1, so the
  // unsigned arithmetic never underflows.
  always_comb begin
    wr_inreq_win = (c32 >= RCD_U - 32'd1) && (c32 <= RCD_U + l32 - 32'd2);
    wr_mask_win  = (c32 >= RCD_U) && (c32 <= RCD_U + l32 - 32'd1);
    rd_mask_win  = (c32 >= RCD_U) && (c32 <= RCD_U + CL_U + l32 - 32'd1);
    rd_valid_win = (c32 >= RCD_U + CL_U + 32'd1) && (c32 <= RCD_U + CL_U + l32);
    stop_pt      = (c32 == RCD_U + l32);
    if (is_rd_q) begin
      xfer_done = (c32 == RCD_U + CL_U + l32 + 32'd1);
    end else begin
      xfer_done = (c32 == RCD_U + l32 + TWR_U);
    end
  end

  // Next-state logic. A write that lost arbitration to a simultaneous read
  // is remembered in wr_pend_q. It is served in the very next IDLE cycle,
  // reusing the address and length captured with the read. The host is
  // allowed to drop WR once ACT rises, so the request level cannot be
  // relied upon. Zero-length requests raise ERR and leave the FSM in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    wr_pend_d = wr_pend_q;
    addr_d    = addr_q;
    len_d     = len_q;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (wr_pend_q) begin
          wr_pend_d = 1'b0;
          is_rd_d   = 1'b0;
          state_d   = S_CMD;
        end else if (RD || WR) begin
          if (LENGTH == '0) begin
            err_d = 1'b1;
          end else begin
            addr_d    = ADDR;
            len_d     = LENGTH;
            is_rd_d   = RD;
            wr_pend_d = RD && WR;
            state_d   = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (CMDACK) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (xfer_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register. Reset aborts any transfer in flight without a
  // DONE pulse and also discards a pending write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      wr_pend_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      wr_pend_q <= wr_pend_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  // Data-path registers. DM is registered every cycle, so the mask driven
  // on DQM in a given cycle is the host mask from the previous cycle. Read
  // data is captured only while a read is in XFER, so DATAOUT stays quiet
  // outside read transfers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dm_q   <= '1;
      data_q <= '0;
    end else begin
      dm_q <= DM;
      if (state_q == S_XFER && is_rd_q) begin
        data_q <= DQ_IN;
      end
    end
  end

  // Output decode. Pulses come straight from the state/counter decode and
  // last exactly one cycle, because the counter moves on every XFER cycle.
  always_comb begin
    CMD       = 2'b00;
    IN_REQ    = 1'b0;
    OUT_VALID = 1'b0;
    PM_STOP   = 1'b0;
    PM_DONE   = 1'b0;
    DONE      = 1'b0;
    DQM       = '1;
    ACT       = (state_q != S_IDLE);
    if (state_q == S_CMD) begin
      CMD = is_rd_q ? 2'b01 : 2'b10;
    end
    if (state_q == S_XFER) begin
      PM_STOP = stop_pt;
      PM_DONE = xfer_done;
      DONE    = xfer_done;
      if (is_rd_q) begin
        OUT_VALID = rd_valid_win;
        if (rd_mask_win) begin
          DQM = '0;
        end
      end else begin
        IN_REQ = wr_inreq_win;
        if (wr_mask_win) begin
          DQM = dm_q;
        end
      end
    end
  end

  assign CMD_ADDR = addr_q;
  assign DATAOUT  = data_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// tb_sdram_burst_sequencer
//
// Directed and randomized stimulus for sdram_burst_sequencer. Expected
// values come from the burst timing rules expressed as cycle offsets from
// command acknowledge. Per-burst totals are also checked: beats delivered,
// write requests and DONE pulses.
`timescale 1ns/1ps
module tb_sdram_burst_sequencer;

  localparam int DSIZE = 16;
  localparam int ASIZE = 23;
  localparam int LEN_W = 8;
  localparam int CL    = 3;
  localparam int RCD   = 3;
  localparam int TWR   = 2;
  localparam int MW    = DSIZE / 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [ASIZE-1:0]  ADDR;
  logic              RD;
  logic              WR;
  logic [LEN_W-1:0]  LENGTH;
  logic [MW-1:0]     DM;
  logic [DSIZE-1:0]  DQ_IN;
  logic              CMDACK;
  logic [1:0]        CMD;
  logic [ASIZE-1:0]  CMD_ADDR;
  logic              ACT;
  logic              IN_REQ;
  logic              OUT_VALID;
  logic [DSIZE-1:0]  DATAOUT;
  logic [MW-1:0]     DQM;
  logic              PM_STOP;
  logic              PM_DONE;
  logic              DONE;
  logic              ERR;

  int n_checks = 0;
  int n_fails  = 0;
  bit ramp_mode = 1'b0;

  // Inputs presented during each XFER cycle, indexed by counter value.
  logic [DSIZE-1:0] dq_at [512];
  logic [MW-1:0]    dm_at [512];

  sdram_burst_sequencer #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .LEN_W(LEN_W),
    .CL(CL), .RCD(RCD), .TWR(TWR)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .RD(RD), .WR(WR),
    .LENGTH(LENGTH), .DM(DM), .DQ_IN(DQ_IN), .CMDACK(CMDACK),
    .CMD(CMD), .CMD_ADDR(CMD_ADDR), .ACT(ACT), .IN_REQ(IN_REQ),
    .OUT_VALID(OUT_VALID), .DATAOUT(DATAOUT), .DQM(DQM),
    .PM_STOP(PM_STOP), .PM_DONE(PM_DONE), .DONE(DONE), .ERR(ERR)
  );

  // Free-running 100 MHz clock.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [LEN_W-1:0] len,
                               input logic [ASIZE-1:0] addr, input logic ack);
    RD     = rd;
    WR     = wr;
    LENGTH = len;
    ADDR   = addr;
    CMDACK = ack;
    DM     = MW'($urandom);
    DQ_IN  = DSIZE'($urandom);
  endtask

  task automatic idleStim();
    applyStimulus(1'b0, 1'b0, LEN_W'($urandom), ASIZE'($urandom), 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_act"},     ACT,       0);
    checkOutput({tag, "_cmd"},     CMD,       0);
    checkOutput({tag, "_inreq"},   IN_REQ,    0);
    checkOutput({tag, "_ovalid"},  OUT_VALID, 0);
    checkOutput({tag, "_done"},    DONE,      0);
    checkOutput({tag, "_pmstop"},  PM_STOP,   0);
    checkOutput({tag, "_pmdone"},  PM_DONE,   0);
    checkOutput({tag, "_dqm"},     DQM,       {MW{1'b1}});
    checkOutput({tag, "_err"},     ERR,       0);
  endtask

  task automatic checkReset(input string tag);
    checkIdle(tag);
    checkOutput({tag, "_cmdaddr"}, CMD_ADDR, 0);
    checkOutput({tag, "_dataout"}, DATAOUT,  0);
  endtask

  // One complete burst. Entered in an IDLE cycle. If drive_rd/drive_wr are
  // both 0, the burst is expected to start from a pending write. In that
  // case exp_addr/len are the values captured earlier, and ADDR/LENGTH carry
  // junk. Returns in the first IDLE cycle after DONE.
  task automatic runBurst(input bit is_rd, input bit drive_rd, input bit drive_wr,
                          input int len, input int ack_delay,
                          input logic [ASIZE-1:0] exp_addr);
    int               c_done;
    int               n_ov;
    int               n_ir;
    int               n_done;
    logic [1:0]       exp_cmd;
    logic             exp_in_req;
    logic             exp_ov;
    logic [MW-1:0]    exp_dqm;
    exp_cmd = is_rd ? 2'b01 : 2'b10;
    n_ov = 0;
    n_ir = 0;
    n_done = 0;
    if (drive_rd || drive_wr) begin
      applyStimulus(drive_rd, drive_wr, LEN_W'(len), exp_addr, 1'b0);
    end else begin
      idleStim();
    end
    tick();
    checkOutput("cmd_issue", CMD, exp_cmd);
    checkOutput("act_cmd", ACT, 1);
    checkOutput("cmd_addr", CMD_ADDR, exp_addr);
    for (int k = 0; k < ack_delay; k++) begin
      idleStim();
      tick();
      checkOutput("cmd_hold", CMD, exp_cmd);
      checkOutput("act_hold", ACT, 1);
    end
    applyStimulus(1'b0, 1'b0, LEN_W'($urandom), ASIZE'($urandom), 1'b1);
    tick();
    c_done = is_rd ? (RCD + CL + len + 1) : (RCD + len + TWR);
    for (int c = 0; c <= c_done; c++) begin
      if (is_rd) begin
        exp_in_req = 1'b0;
        exp_ov     = (c >= RCD + CL + 1) && (c <= RCD + CL + len);
        exp_dqm    = ((c >= RCD) && (c <= RCD + CL + len - 1)) ? '0 : '1;
      end else begin
        exp_in_req = (c >= RCD - 1) && (c <= RCD + len - 2);
        exp_ov     = 1'b0;
        if ((c >= RCD) && (c <= RCD + len - 1)) begin
          exp_dqm = dm_at[c-1];
        end else begin
          exp_dqm = '1;
        end
      end
      checkOutput("act_xfer", ACT, 1);
      checkOutput("cmd_xfer", CMD, 0);
      checkOutput("in_req", IN_REQ, exp_in_req);
      checkOutput("out_valid", OUT_VALID, exp_ov);
      checkOutput("dqm", DQM, exp_dqm);
      checkOutput("pm_stop", PM_STOP, (c == RCD + len) ? 1 : 0);
      checkOutput("pm_done", PM_DONE, (c == c_done) ? 1 : 0);
      checkOutput("done", DONE, (c == c_done) ? 1 : 0);
      checkOutput("err_xfer", ERR, 0);
      if (exp_ov) begin
        checkOutput("dataout", DATAOUT, dq_at[c-1]);
        if (ramp_mode) begin
          checkOutput("dataout_ramp", DATAOUT, 32'h100 + 32'(c - RCD - CL - 1));
        end
      end
      if (OUT_VALID === 1'b1) n_ov++;
      if (IN_REQ === 1'b1) n_ir++;
      if (DONE === 1'b1) n_done++;
      idleStim();
      if (ramp_mode && c >= RCD + CL) begin
        DQ_IN = DSIZE'(16'h100 + 16'(c - RCD - CL));
      end
      dq_at[c] = DQ_IN;
      dm_at[c] = DM;
      tick();
    end
    checkOutput("beat_count", n_ov, is_rd ? len : 0);
    checkOutput("inreq_count", n_ir, is_rd ? 0 : len);
    checkOutput("done_count", n_done, 1);
    checkIdle("after_done");
  endtask

  initial begin
    logic [ASIZE-1:0] addr;
    int               len;
    bit               dir;

    $display("[TB] sdram_burst_sequencer bench starting");
    RESET = 1'b1;
    idleStim();
    tick();
    tick();
    checkReset("reset");
    RESET = 1'b0;
    tick();
    checkReset("post_reset");

    // Write L=4 with CMDACK two cycles after CMD appears.
    $display("[TB] write L=4");
    runBurst(1'b0, 1'b0, 1'b1, 4, 2, ASIZE'(23'h012345));

    // Read L=8 with a ramp on DQ_IN; streams straight from the previous DONE.
    $display("[TB] read L=8 ramp");
    ramp_mode = 1'b1;
    runBurst(1'b1, 1'b1, 1'b0, 8, 1, ASIZE'(23'h000100));
    ramp_mode = 1'b0;

    // Simultaneous read and write: read first, pending write one IDLE later.
    $display("[TB] read/write arbitration");
    addr = ASIZE'($urandom);
    runBurst(1'b1, 1'b1, 1'b1, 2, 0, addr);
    runBurst(1'b0, 1'b0, 1'b0, 2, 1, addr);
    idleStim();
    tick();
    checkIdle("no_extra_pend");

    // Zero-length requests are rejected.
    $display("[TB] zero-length requests");
    applyStimulus(1'b0, 1'b1, '0, ASIZE'($urandom), 1'b0);
    tick();
    checkOutput("err_pulse", ERR, 1);
    checkOutput("err_act", ACT, 0);
    checkOutput("err_cmd", CMD, 0);
    checkOutput("err_done", DONE, 0);
    idleStim();
    tick();
    checkIdle("err_clear");
    applyStimulus(1'b1, 1'b1, '0, ASIZE'($urandom), 1'b0);
    tick();
    checkOutput("err_both", ERR, 1);
    checkOutput("err_both_act", ACT, 0);
    for (int i = 0; i < 4; i++) begin
      idleStim();
      tick();
      checkIdle("err_both_after");
    end

    // Reset at C=5 of a 16-beat read aborts silently.
    $display("[TB] reset during read");
    applyStimulus(1'b1, 1'b0, LEN_W'(16), ASIZE'($urandom), 1'b0);
    tick();
    checkOutput("abort_act", ACT, 1);
    applyStimulus(1'b0, 1'b0, LEN_W'($urandom), ASIZE'($urandom), 1'b1);
    tick();
    for (int c = 0; c < 5; c++) begin
      idleStim();
      tick();
    end
    checkOutput("abort_act_c5", ACT, 1);
    idleStim();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checkReset("abort");
    for (int i = 0; i < 20; i++) begin
      idleStim();
      tick();
      checkReset("abort_quiet");
    end

    // Maximum-length read.
    $display("[TB] read L=255");
    runBurst(1'b1, 1'b1, 1'b0, 255, 0, ASIZE'($urandom));

    // Randomized streaming bursts with occasional idle gaps.
    $display("[TB] random bursts");
    for (int i = 0; i < 14; i++) begin
      dir  = 1'($urandom);
      len  = int'($urandom_range(1, 24));
      addr = ASIZE'($urandom);
      runBurst(dir, dir, !dir, len, int'($urandom_range(0, 3)), addr);
      if ($urandom_range(0, 2) == 0) begin
        idleStim();
        tick();
        checkIdle("gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
